// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the M-extension multiply/divide unit: ALUOp codes and FSM state encodings.
package muldiv_unit_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_MUL    = 4'h8;
    localparam logic [3:0] OP_MULH   = 4'h9;
    localparam logic [3:0] OP_MULHSU = 4'hA;
    localparam logic [3:0] OP_MULHU  = 4'hB;
    localparam logic [3:0] OP_DIV    = 4'hC;
    localparam logic [3:0] OP_DIVU   = 4'hD;
    localparam logic [3:0] OP_REM    = 4'hE;
    localparam logic [3:0] OP_REMU   = 4'hF;

    localparam logic [1:0] MULDIV_IDLE = 2'd0;
    localparam logic [1:0] MULDIV_CALC = 2'd1;
    localparam logic [1:0] MULDIV_FIX  = 2'd2;
    localparam logic [1:0] MULDIV_DONE = 2'd3;

    typedef enum logic [1:0] {
        StIdle = MULDIV_IDLE,
        StCalc = MULDIV_CALC,
        StFix  = MULDIV_FIX,
        StDone = MULDIV_DONE
    } muldiv_state_e;

    function automatic logic is_m_op(input logic [3:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                          OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring divide step: shift the next dividend bit into the remainder, subtract if it fits.
module div_step (
    input  logic [31:0] rem_in,
    input  logic [31:0] divisor,
    input  logic        q_in,
    output logic [31:0] rem_out,
    output logic        q_out
);

    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {rem_in, q_in};
    assign diff    = shifted - {1'b0, divisor};
    // A set bit 32 means the shifted value already exceeds any 32-bit divisor.
    assign q_out   = shifted[32] | ~diff[32];
    assign rem_out = q_out ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed latency.
// Define MULDIV_FAST_MUL_EN to compute the multiply ops with a single-cycle multiplier.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  ALUOp,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    muldiv_state_e state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] result_q, result_d;

    logic        is_div, is_rem, a_neg, b_neg, neg_in;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [31:0] div_rem;
    logic        div_q;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign is_div = ALUOp[2];
    assign is_rem = ALUOp[2] & ALUOp[1];
    // MUL is treated as signed so the recorded sign matches sign(A) xor sign(B).
    assign a_neg  = inA[31] & (ALUOp inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign b_neg  = inB[31] & (ALUOp inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    assign a_mag  = a_neg ? -inA : inA;
    assign b_mag  = b_neg ? -inB : inB;
    assign neg_in = !is_div ? (a_neg ^ b_neg) :
                    is_rem  ? a_neg : ((a_neg ^ b_neg) & (inB != 32'd0));

    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

    div_step u_div_step (
        .rem_in  (acc_q[63:32]),
        .divisor (opnd_q),
        .q_in    (acc_q[31]),
        .rem_out (div_rem),
        .q_out   (div_q)
    );

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = neg_q ? -acc_q[63:32] : acc_q[63:32];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (kill) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (start && is_m_op(ALUOp)) begin
                        op_d   = ALUOp;
                        neg_d  = neg_in;
                        cnt_d  = 6'd0;
                        state_d = StCalc;
                        if (is_div) begin
                            opnd_d = b_mag;
                            acc_d  = {32'd0, a_mag};
                        end else begin
                            opnd_d = a_mag;
`ifdef MULDIV_FAST_MUL_EN
                            acc_d   = 64'(a_mag) * 64'(b_mag);
                            state_d = StFix;
`else
                            acc_d  = {32'd0, b_mag};
`endif
                        end
                    end
                end
                StCalc: begin
                    acc_d = op_q[2] ? {div_rem, acc_q[30:0], div_q} : {mul_sum, acc_q[31:1]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    unique case (op_q)
                        OP_MUL:                       result_d = prod_fix[31:0];
                        OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[63:32];
                        OP_DIV, OP_DIVU:              result_d = quo_fix;
                        default:                      result_d = rem_fix;
                    endcase
                    state_d = StDone;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= 4'd0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StCalc) || (state_q == StFix);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit using an expected-result queue.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clock, reset, start, kill;
    logic [3:0]  ALUOp;
    logic [31:0] inA, inB;
    logic        busy, done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    logic        done_seen;

    muldiv_unit dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .ALUOp  (ALUOp),
        .inA    (inA),
        .inB    (inB),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [3:0] op);
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        exp_q.push_back(exp);
        start = 1'b1;
        ALUOp = op;
        inA   = a;
        inB   = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat, input string tag);
        int          n;
        logic        busy_ok;
        logic [31:0] exp;
        n       = 0;
        busy_ok = 1'b1;
        while (!done && n < 60) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check({tag, " result"}, result, exp);
        last_exp = exp;
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
        issue(op, a, b, exp);
        wait_done(lat_of(op), tag);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        ALUOp = OP_ADD;
        inA   = 32'd0;
        inB   = 32'd0;
        tick();
        tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        tick();

        run(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        run(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        run(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div");
        run(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem");
        run(OP_DIVU,   32'd100,      32'd7,        32'd14,       "divu");
        run(OP_REMU,   32'd100,      32'd7,        32'd2,        "remu");
        run(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, "divu by zero");
        run(OP_REM,    32'd5,        32'd0,        32'd5,        "rem by zero");
        run(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div overflow");
        run(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem overflow");

        // A start while busy must not disturb the running divide.
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
        tick();
        start = 1'b1;
        ALUOp = OP_MUL;
        inA   = 32'd3;
        inB   = 32'd3;
        tick();
        start = 1'b0;
        tick();
        wait_done(30, "start while busy");

        run(OP_REMU, 32'd100, 32'd7, 32'd2, "pre-kill");
        issue(OP_DIV, 32'd100, 32'd7, 32'd14);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        exp_q.delete();
        check("kill busy", {31'd0, busy}, 32'd0);
        check("kill done", {31'd0, done}, 32'd0);
        done_seen = 1'b0;
        repeat (40) begin
            if (done) done_seen = 1'b1;
            tick();
        end
        check("kill no done", {31'd0, done_seen}, 32'd0);
        check("kill result kept", result, last_exp);

        start = 1'b1;
        ALUOp = OP_ADD;
        inA   = 32'd1;
        inB   = 32'd2;
        tick();
        start = 1'b0;
        check("add ignored busy", {31'd0, busy}, 32'd0);
        done_seen = 1'b0;
        repeat (5) begin
            if (done) done_seen = 1'b1;
            tick();
        end
        check("add ignored done", {31'd0, done_seen}, 32'd0);
        check("add ignored result", result, last_exp);

        // Second start lands in the DONE cycle of the first.
        run(OP_DIVU, 32'd100, 32'd7, 32'd14, "b2b first");
        issue(OP_REMU, 32'd100, 32'd7, 32'd2);
        check("b2b accepted", {31'd0, busy}, 32'd1);
        wait_done(33, "b2b second");

        issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        check("mid reset result", result, 32'd0);
        run(OP_DIVU, 32'd9, 32'd3, 32'd3, "divu after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
